// File: rtl/nv_ram_fifo_ctrl_32x128_if.sv
// nv_ram_fifo_ctrl_32x128_if: write/read valid-ready channels of the 32x128 RAM FIFO controller
interface nv_ram_fifo_ctrl_32x128_if;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [127:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [127:0] rd_pd;
  modport master (output wr_pvld, wr_pd, rd_prdy, input wr_prdy, rd_pvld, rd_pd);
  modport slave  (input wr_pvld, wr_pd, rd_prdy, output wr_prdy, rd_pvld, rd_pd);
endinterface

// File: rtl/nv_ram_fifo_ctrl_32x128.sv
// nv_ram_fifo_ctrl_32x128: 32-deep 128-bit FIFO controller over an external 1-cycle-latency RAM with a 2-entry output stage
// Define NV_FIFO_CTRL_AFULL_EN to add the registered wr_afull output.
module nv_ram_fifo_ctrl_32x128 #(
  parameter logic [5:0] AFULL_LVL = 6'd28
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  nv_ram_fifo_ctrl_32x128_if.slave   io,
  output logic                       ram_we,
  output logic [4:0]                 ram_wa,
  output logic [127:0]               ram_di,
  output logic                       ram_re,
  output logic [4:0]                 ram_ra,
  input  logic [127:0]               ram_dout,
  output logic [5:0]                 fifo_cnt,
  input  logic [31:0]                pwrbus_ram_pd,
  output logic [31:0]                pwrbus_ram_pd_o
`ifdef NV_FIFO_CTRL_AFULL_EN
  ,
  output logic                       wr_afull
`endif
);
  logic [4:0]   wr_ptr, rd_ptr;
  logic [5:0]   ram_cnt, ram_cnt_nxt;
  logic         inflight, pop;
  logic [1:0]   out_cnt, out_base, out_nxt;
  logic [127:0] ob0, ob1;
  assign io.wr_prdy      = !ram_cnt[5];
  assign ram_we          = io.wr_pvld & io.wr_prdy;
  assign ram_wa          = wr_ptr;
  assign ram_di          = io.wr_pd;
  assign pop             = io.rd_pvld & io.rd_prdy;
  assign out_base        = out_cnt - {1'b0, pop};
  assign out_nxt         = out_base + {1'b0, inflight};
  // ram_cnt only counts entries from earlier cycles, so a same-cycle write is never read-issued
  assign ram_re          = (ram_cnt != 6'd0) && (out_nxt < 2'd2);
  assign ram_ra          = rd_ptr;
  assign ram_cnt_nxt     = ram_cnt + {5'd0, ram_we} - {5'd0, ram_re};
  assign io.rd_pvld      = out_cnt != 2'd0;
  assign io.rd_pd        = ob0;
  assign fifo_cnt        = ram_cnt + {5'd0, inflight} + {4'd0, out_cnt};
  assign pwrbus_ram_pd_o = pwrbus_ram_pd;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= 5'd0;
      rd_ptr   <= 5'd0;
      ram_cnt  <= 6'd0;
      inflight <= 1'b0;
      out_cnt  <= 2'd0;
      ob0      <= 128'd0;
      ob1      <= 128'd0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + 5'd1;
      if (ram_re) rd_ptr <= rd_ptr + 5'd1;
      ram_cnt  <= ram_cnt_nxt;
      inflight <= ram_re;
      out_cnt  <= out_nxt;
      if (pop) ob0 <= ob1;
      // returning RAM data lands in the first slot left free after this cycle's pop
      if (inflight) begin
        if (out_base == 2'd0) ob0 <= ram_dout;
        else ob1 <= ram_dout;
      end
    end
  end
`ifdef NV_FIFO_CTRL_AFULL_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) wr_afull <= 1'b0;
    else wr_afull <= (ram_cnt_nxt + {5'd0, ram_re} + {4'd0, out_nxt}) >= AFULL_LVL;
  end
`endif
endmodule

// File: tb/tb_nv_ram_fifo_ctrl_32x128.sv
// tb_nv_ram_fifo_ctrl_32x128: directed vector table plus scoreboarded sequences for the RAM FIFO controller
module tb_nv_ram_fifo_ctrl_32x128;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ram_we, ram_re;
  logic [4:0]   ram_wa, ram_ra;
  logic [127:0] ram_di, ram_dout;
  logic [5:0]   fifo_cnt;
  logic [31:0]  pwr_o;
  logic [127:0] mem [32];
`ifdef NV_FIFO_CTRL_AFULL_EN
  logic         wr_afull;
`endif
  nv_ram_fifo_ctrl_32x128_if bus ();
  nv_ram_fifo_ctrl_32x128 dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .io(bus),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_dout(ram_dout),
    .fifo_cnt(fifo_cnt), .pwrbus_ram_pd(32'h1234_5678), .pwrbus_ram_pd_o(pwr_o)
`ifdef NV_FIFO_CTRL_AFULL_EN
    , .wr_afull(wr_afull)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    ram_dout <= ram_re ? mem[ram_ra] : {$urandom, $urandom, $urandom, $urandom};
  end
  typedef struct {
    logic wp; logic [127:0] pd; logic rp;
    logic e_prdy; logic e_we; logic [4:0] e_wa; logic e_re; logic [4:0] e_ra;
    logic e_pvld; logic [127:0] e_rpd; logic [5:0] e_cnt;
  } vec_t;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] B1 = {4{32'hB1B1_0001}};
  localparam logic [127:0] B2 = {4{32'hB2B2_0002}};
  vec_t tv [14];
  int total = 0, bad = 0;
  int beat = 0, acc = 0, pops = 0, both = 0, n = 0;
  logic last_acc, last_pop, stall_q = 1'b0, seen;
  logic [127:0] prev_pd;
  logic [127:0] q [$];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] mk(input int b);
    return {b, ~b, b * 7, 32'hA5A5_0000 + b};
  endfunction
  task automatic step(input logic wp, input logic rp);
    @(negedge clk);
    bus.wr_pvld = wp;
    bus.wr_pd   = mk(beat);
    bus.rd_prdy = rp;
    #1;
    if (stall_q) begin
      chk("stall_pvld", bus.rd_pvld, 1'b1);
      chk("stall_pd", bus.rd_pd, prev_pd);
    end
    last_acc = bus.wr_pvld && bus.wr_prdy;
    last_pop = bus.rd_pvld && bus.rd_prdy;
    if (last_acc) begin
      q.push_back(bus.wr_pd);
      beat++;
      acc++;
    end
    if (last_pop) begin
      chk("pop_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) chk("order", bus.rd_pd, q.pop_front());
      pops++;
    end
    stall_q = bus.rd_pvld && !bus.rd_prdy;
    prev_pd = bus.rd_pd;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step(1'b0, 1'b1);
    chk("drain_empty", q.size(), 0);
    step(1'b0, 1'b1);
    chk("drain_cnt", fifo_cnt, 6'd0);
  endtask
  task automatic chk_reset();
    chk("rst_pvld", bus.rd_pvld, 1'b0);
    chk("rst_pd", bus.rd_pd, 128'd0);
    chk("rst_re", ram_re, 1'b0);
    chk("rst_cnt", fifo_cnt, 6'd0);
    chk("rst_prdy", bus.wr_prdy, 1'b1);
    chk("rst_we", ram_we, 1'b0);
`ifdef NV_FIFO_CTRL_AFULL_EN
    chk("rst_afull", wr_afull, 1'b0);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0]  = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'd0, 6'd0};
    tv[1]  = '{1'b1, A5,     1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 128'd0, 6'd0};
    tv[2]  = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 128'd0, 6'd1};
    tv[3]  = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'd0, 6'd1};
    tv[4]  = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, A5,     6'd1};
    tv[5]  = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'd0, 6'd0};
    tv[6]  = '{1'b1, B1,     1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 128'd0, 6'd0};
    tv[7]  = '{1'b1, B2,     1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0, 128'd0, 6'd1};
    tv[8]  = '{1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 128'd0, 6'd2};
    tv[9]  = '{1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, B1,     6'd2};
    tv[10] = '{1'b0, 128'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, B1,     6'd2};
    tv[11] = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, B1,     6'd2};
    tv[12] = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, B2,     6'd1};
    tv[13] = '{1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 128'd0, 6'd0};
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = 128'd0;
    bus.rd_prdy = 1'b0;
    #3;
    chk_reset();
    chk("pwrbus", pwr_o, 32'h1234_5678);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.wr_pvld = tv[i].wp;
      bus.wr_pd   = tv[i].pd;
      bus.rd_prdy = tv[i].rp;
      #1;
      chk($sformatf("v%0d_prdy", i), bus.wr_prdy, tv[i].e_prdy);
      chk($sformatf("v%0d_we", i), ram_we, tv[i].e_we);
      if (tv[i].e_we) chk($sformatf("v%0d_wa", i), ram_wa, tv[i].e_wa);
      chk($sformatf("v%0d_re", i), ram_re, tv[i].e_re);
      if (tv[i].e_re) chk($sformatf("v%0d_ra", i), ram_ra, tv[i].e_ra);
      chk($sformatf("v%0d_pvld", i), bus.rd_pvld, tv[i].e_pvld);
      if (tv[i].e_pvld) chk($sformatf("v%0d_rpd", i), bus.rd_pd, tv[i].e_rpd);
      chk($sformatf("v%0d_cnt", i), fifo_cnt, tv[i].e_cnt);
    end
    // fill with reads stalled: 32 in RAM plus 2 in the output stage
    n = acc;
    repeat (40) step(1'b1, 1'b0);
    chk("fill_accepts", acc - n, 34);
    step(1'b0, 1'b0);
    chk("full_prdy", bus.wr_prdy, 1'b0);
    chk("full_cnt", fifo_cnt, 6'd34);
    drain();
    // streaming: one accept and one pop every cycle across pointer wraps
    repeat (10) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    both = 0;
    repeat (100) begin
      step(1'b1, 1'b1);
      if (last_acc && last_pop) both++;
    end
    chk("stream_both", both, 100);
    drain();
    for (int i = 0; i < 60; i++) step(1'b1, i[0] == 1'b0);
    drain();
    chk("acc_eq_pops", acc, pops);
    // reset mid-operation with a RAM read in flight
    repeat (10) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("pre_rst_re", ram_re, 1'b1);
    @(posedge clk);
    #2;
    bus.rd_prdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset();
    q.delete();
    stall_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b1);
      n++;
      if (n == 1) begin
        chk("post_rst_re", ram_re, 1'b1);
        chk("post_rst_ra", ram_ra, 5'd0);
      end
      seen = last_pop;
    end
    chk("post_rst_latency", n, 3);
    drain();
`ifdef NV_FIFO_CTRL_AFULL_EN
    repeat (27) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("afull_27_cnt", fifo_cnt, 6'd27);
    chk("afull_27", wr_afull, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("afull_28", wr_afull, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("afull_pop", wr_afull, 1'b0);
    drain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nv_ram_fifo_ctrl_32x128.md
NV_RAM_FIFO_CTRL_32X128 -- requirements
Module: nv_ram_fifo_ctrl_32x128

Interface
REQ-001 SHALL have parameter AFULL_LVL, default 6'd28, almost-full threshold on total occupancy (used only under NV_FIFO_CTRL_AFULL_EN).
REQ-002 SHALL have port nvdla_core_clk  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_pvld  input  1  write request valid.
REQ-005 SHALL have port wr_prdy  output  1  write accept (combinational from state).
REQ-006 SHALL have port wr_pd  input  128  write payload.
REQ-007 SHALL have port rd_pvld  output  1  read data valid (registered).
REQ-008 SHALL have port rd_prdy  input  1  read consumer ready.
REQ-009 SHALL have port rd_pd  output  128  read payload (registered).
REQ-010 SHALL have ports ram_we/ram_wa/ram_di  output  1/5/128  RAM write strobe, address, data.
REQ-011 SHALL have ports ram_re/ram_ra  output  1/5  RAM read strobe, address.
REQ-012 SHALL have port ram_dout  input  128  RAM read data, valid the cycle after ram_re, not held.
REQ-013 SHALL have port fifo_cnt  output  6  total entries held (RAM + in-flight + output stage), 0..34.
REQ-014 SHALL have port pwrbus_ram_pd  input  32  RAM power-down bus, passed unchanged to pwrbus_ram_pd_o (output 32).

Function
REQ-015 SHALL accept a write when wr_pvld & wr_prdy; wr_prdy = (ram_cnt < 32), ram_cnt = entries written and not yet read-issued.
REQ-016 SHALL drive ram_we = wr_pvld & wr_prdy, ram_wa = wr_ptr, ram_di = wr_pd combinationally; wr_ptr increments mod 32 on accept.
REQ-017 SHALL issue ram_re only for entries written in an earlier cycle (a same-cycle write is never read-issued).
REQ-018 SHALL issue ram_re, ram_ra = rd_ptr, when readable ram_cnt > 0 and (out_cnt + inflight - pop) < 2; rd_ptr increments mod 32 on issue.
REQ-019 SHALL capture ram_dout into a 2-entry output buffer at the edge ending the cycle after ram_re (inflight flag = 1 for exactly that cycle).
REQ-020 SHALL present the oldest output-buffer entry on rd_pd with rd_pvld = (out_cnt > 0); pop = rd_pvld & rd_prdy.
REQ-021 SHALL preserve strict FIFO order; rd_pd SHALL stay stable while rd_pvld & !rd_prdy.
REQ-022 SHALL give empty-FIFO latency of 3 cycles: accept at edge E, ram_re in cycle E+1, rd_pvld=1 in cycle E+3.
REQ-023 SHALL sustain one write and one read per cycle in steady state, no bubbles.
REQ-024 SHALL update ram_cnt for simultaneous accept and read-issue as net zero; wr_prdy stays 1 when full-RAM write coincides with issue only on the following cycle (no same-cycle bypass).
REQ-025 SHALL compute fifo_cnt = ram_cnt + inflight + out_cnt, registered-state derived, never exceeding 34.

Reset
REQ-026 SHALL on nvdla_core_rstn low asynchronously clear wr_ptr, rd_ptr, ram_cnt, inflight, out_cnt; rd_pvld=0, rd_pd=0, ram_re=0, fifo_cnt=0, wr_prdy=1, ram_we=0 while wr_pvld=0.
REQ-027 SHALL discard all contents and any in-flight read on reset mid-operation; RAM array contents are not cleared.

Configuration
REQ-028 SHALL, with NV_FIFO_CTRL_AFULL_EN defined, add output wr_afull (1 bit, registered) = (fifo_cnt >= AFULL_LVL), reset 0.
REQ-029 SHALL, without NV_FIFO_CTRL_AFULL_EN, omit wr_afull port and logic; all other behaviour identical.

Verification
REQ-030 Reset then single write 128'hA5..A5 at edge E -> ram_re in E+1 with ram_ra=0, rd_pvld=1 and rd_pd=A5..A5 in E+3, fifo_cnt=1.
REQ-031 rd_prdy=0, write 40 beats back-to-back -> 34 accepted, wr_prdy=0 after 34th, fifo_cnt=34, then drain yields beats 0..33 in order.
REQ-032 Continuous write+read 100 beats after fill -> one accept and one pop every cycle, wr_ptr/rd_ptr wrap 31->0 with no data error.
REQ-033 rd_prdy toggled 1/0 each cycle under full write load -> rd_pd stable while stalled, no loss or duplication.
REQ-034 Assert nvdla_core_rstn low with 10 entries and a read in flight -> all outputs at reset values immediately; next write returns after 3 cycles, old data never seen.
REQ-035 With NV_FIFO_CTRL_AFULL_EN, AFULL_LVL=28, fill 27 -> wr_afull=0; 28th accept -> wr_afull=1 next cycle; one pop -> 0.
